// File: rtl/riscv_pkg.sv
// Shared core definitions: funct3 codes, reset entry point and base opcodes.
// Also holds the access-size alignment rule used by the memory arbiter.
package riscv_pkg;

  localparam logic [31:0] ENTRY = 32'h8000_0000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  // Bytes may sit at any offset; halfwords need an even address, words a 4-byte one.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a memory word and extends it.
// Unknown funct3 codes produce zero.
module load_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] result
);
  import riscv_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    result   = '0;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'b0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'b0, half_sel};
      F3_W:    result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered-read RAM port between instruction fetch and load/store,
// handling address translation, byte lanes, load alignment and access errors.
module mem_arbiter #(
  parameter logic [31:0] ENTRY    = riscv_pkg::ENTRY,
  parameter int unsigned DEPTH    = 2056,
  parameter int unsigned AW       = 12,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_valid,
  input  logic [31:0]   if_addr,
  output logic          if_ready,
  output logic          if_rsp_valid,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          d_valid,
  input  logic          d_we,
  input  logic [2:0]    d_funct3,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ready,
  output logic          d_rsp_valid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  import riscv_pkg::*;

  localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [31:0]   if_idx, d_idx;
  logic          if_req_err, d_req_err, d_f3_bad;
  logic [1:0]    d_off;
  logic          if_grant, d_grant, fetch_prio;
  logic [3:0]    lane_we;
  logic [31:0]   lane_wdata, load_word;
  logic          rsp_live;

  logic [WW-1:0] wait_q, wait_d;
  logic          rsp_valid_q, rsp_valid_d;
  req_id_e       rsp_id_q, rsp_id_d;
  logic [2:0]    rsp_funct3_q, rsp_funct3_d;
  logic [1:0]    rsp_off_q, rsp_off_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_store_q, rsp_store_d;

  always_comb begin
    if_idx     = (if_addr - ENTRY) >> 2;
    if_req_err = (if_addr < ENTRY) || (if_idx >= DEPTH) || (if_addr[1:0] != 2'b00);
    d_idx      = (d_addr - ENTRY) >> 2;
    d_off      = d_addr[1:0];
    if (d_we) d_f3_bad = !(d_funct3 inside {F3_B, F3_H, F3_W});
    else      d_f3_bad = !(d_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    d_req_err  = (d_addr < ENTRY) || (d_idx >= DEPTH) || d_f3_bad || misaligned(d_funct3, d_off);
  end

  // Data normally wins; fetch takes the port once it has lost MAX_WAIT times in a row.
  always_comb begin
    fetch_prio = (wait_q == WW'(MAX_WAIT));
    if_grant   = !reset && if_valid && (!d_valid || fetch_prio);
    d_grant    = !reset && d_valid && !if_grant;
    wait_d     = wait_q;
    if (!if_valid || if_grant) wait_d = '0;
    else if (!fetch_prio)      wait_d = wait_q + WW'(1);
  end

  always_comb begin
    lane_we    = '0;
    lane_wdata = '0;
    case (d_funct3)
      F3_B: begin
        lane_we    = 4'b0001 << d_off;
        lane_wdata = {4{d_wdata[7:0]}};
      end
      F3_H: begin
        lane_we    = 4'b0011 << d_off;
        lane_wdata = {2{d_wdata[15:0]}};
      end
      F3_W: begin
        lane_we    = 4'b1111;
        lane_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  // Rejected requests are still granted and answered, but never touch the RAM.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_grant && !if_req_err) begin
      mem_en   = 1'b1;
      mem_addr = if_idx[AW-1:0];
    end else if (d_grant && !d_req_err) begin
      mem_en   = 1'b1;
      mem_addr = d_idx[AW-1:0];
      if (d_we) begin
        mem_we    = lane_we;
        mem_wdata = lane_wdata;
      end
    end
  end

  always_comb begin
    rsp_valid_d  = if_grant || d_grant;
    rsp_id_d     = d_grant ? REQ_D : REQ_IF;
    rsp_funct3_d = d_funct3;
    rsp_off_d    = d_off;
    rsp_err_d    = d_grant ? d_req_err : if_req_err;
    rsp_store_d  = d_grant && d_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= REQ_IF;
      rsp_funct3_q <= '0;
      rsp_off_q    <= '0;
      rsp_err_q    <= 1'b0;
      rsp_store_q  <= 1'b0;
    end else begin
      wait_q       <= wait_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_funct3_q <= rsp_funct3_d;
      rsp_off_q    <= rsp_off_d;
      rsp_err_q    <= rsp_err_d;
      rsp_store_q  <= rsp_store_d;
    end
  end

  load_align u_load_align (
    .funct3 (rsp_funct3_q),
    .off    (rsp_off_q),
    .word   (mem_rdata),
    .result (load_word)
  );

  // A response still in flight when reset rises is dropped immediately.
  always_comb begin
    if_ready     = if_grant;
    d_ready      = d_grant;
    rsp_live     = rsp_valid_q && !reset;
    if_rsp_valid = rsp_live && (rsp_id_q == REQ_IF);
    d_rsp_valid  = rsp_live && (rsp_id_q == REQ_D);
    if_err       = if_rsp_valid && rsp_err_q;
    d_err        = d_rsp_valid && rsp_err_q;
    if_rdata     = (if_rsp_valid && !rsp_err_q) ? mem_rdata : '0;
    d_rdata      = (d_rsp_valid && !rsp_err_q && !rsp_store_q) ? load_word : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a write-first RAM model behind the DUT,
// expected responses queued at grant time and matched one cycle later.
module tb_mem_arbiter;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_valid = 1'b0;
  logic [31:0]   if_addr = '0;
  logic          if_ready, if_rsp_valid, if_err;
  logic [31:0]   if_rdata;
  logic          d_valid = 1'b0;
  logic          d_we = 1'b0;
  logic [2:0]    d_funct3 = '0;
  logic [31:0]   d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic          d_ready, d_rsp_valid, d_err;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        if_q[$];
  rsp_t        d_q[$];
  rsp_t        mon_rsp;
  int          cycle = 0;
  int          checks = 0;
  int          fails = 0;
  int          wait_model = 0;
  logic [31:0] ram [0:4095] = '{default: 32'h0};

  mem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .if_valid     (if_valid),
    .if_addr      (if_addr),
    .if_ready     (if_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rdata     (if_rdata),
    .if_err       (if_err),
    .d_valid      (d_valid),
    .d_we         (d_we),
    .d_funct3     (d_funct3),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_ready      (d_ready),
    .d_rsp_valid  (d_rsp_valid),
    .d_rdata      (d_rdata),
    .d_err        (d_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] wd);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  // Registered-read, write-first RAM
  always @(posedge clk) begin
    if (mem_en) begin
      ram[mem_addr] <= merge(ram[mem_addr], mem_we, mem_wdata);
      mem_rdata     <= merge(ram[mem_addr], mem_we, mem_wdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Drives one cycle, checks the grant against an arbitration model and queues the response.
  task automatic applyStimulus(input logic rst, input logic iv, input logic [31:0] ia,
                               input logic dv, input logic dwe, input logic [2:0] f3,
                               input logic [31:0] da, input logic [31:0] dwd,
                               input logic [31:0] exp_i_data, input logic exp_i_err,
                               input logic [31:0] exp_d_data, input logic exp_d_err,
                               input logic push_rsp);
    logic exp_if, exp_d;
    rsp_t r;
    @(posedge clk);
    #2;
    reset = rst; if_valid = iv; if_addr = ia;
    d_valid = dv; d_we = dwe; d_funct3 = f3; d_addr = da; d_wdata = dwd;
    #1;
    exp_if = !rst && iv && (!dv || wait_model == 3);
    exp_d  = !rst && dv && !exp_if;
    checkOutput("if_ready", 32'(if_ready), 32'(exp_if));
    checkOutput("d_ready", 32'(d_ready), 32'(exp_d));
    if (rst || !iv || exp_if) wait_model = 0;
    else wait_model++;
    if (push_rsp && exp_if) begin
      r.cyc = cycle + 1; r.rdata = exp_i_data; r.err = exp_i_err;
      if_q.push_back(r);
    end
    if (push_rsp && exp_d) begin
      r.cyc = cycle + 1; r.rdata = exp_d_data; r.err = exp_d_err;
      d_q.push_back(r);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 3'b000, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic fetchReq(input logic [31:0] a, input logic [31:0] data, input logic err);
    applyStimulus(1'b0, 1'b1, a, 1'b0, 1'b0, 3'b000, '0, '0, data, err, '0, 1'b0, 1'b1);
  endtask

  task automatic dataReq(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] data, input logic err);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, we, f3, a, wd, '0, 1'b0, data, err, 1'b1);
  endtask

  // Response monitor: each port must pulse exactly in the cycle its queue head names
  always @(negedge clk) begin
    if (if_q.size() > 0 && if_q[0].cyc == cycle) begin
      checkOutput("if_rsp_valid", 32'(if_rsp_valid), 32'd1);
      mon_rsp = if_q.pop_front();
      checkOutput("if_rdata", if_rdata, mon_rsp.rdata);
      checkOutput("if_err", 32'(if_err), 32'(mon_rsp.err));
    end else begin
      checkOutput("if_rsp_idle", 32'(if_rsp_valid), 32'd0);
    end
    if (d_q.size() > 0 && d_q[0].cyc == cycle) begin
      checkOutput("d_rsp_valid", 32'(d_rsp_valid), 32'd1);
      mon_rsp = d_q.pop_front();
      checkOutput("d_rdata", d_rdata, mon_rsp.rdata);
      checkOutput("d_err", 32'(d_err), 32'(mon_rsp.err));
    end else begin
      checkOutput("d_rsp_idle", 32'(d_rsp_valid), 32'd0);
    end
  end

  initial begin
    $display("[TB] starting mem_arbiter bench");

    // Requests during reset must be ignored
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 3'b010, 32'h8000_0000,
                    32'hFFFF_FFFF, '0, 1'b0, '0, 1'b0, 1'b1);
      checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    end

    dataReq(1'b1, 3'b010, 32'h8000_0000, 32'h0000_0513, 32'h0, 1'b0);
    checkOutput("sw0_we", 32'(mem_we), 32'hF);
    checkOutput("sw0_addr", 32'(mem_addr), 32'd0);
    checkOutput("sw0_wdata", mem_wdata, 32'h0000_0513);
    dataReq(1'b1, 3'b010, 32'h8000_201C, 32'hCAFE_F00D, 32'h0, 1'b0);
    checkOutput("sw_last_addr", 32'(mem_addr), 32'd2055);

    fetchReq(32'h8000_0000, 32'h0000_0513, 1'b0);
    checkOutput("fetch_mem_en", 32'(mem_en), 32'd1);

    dataReq(1'b1, 3'b000, 32'h8000_0006, 32'h1234_56AB, 32'h0, 1'b0);
    checkOutput("sb_we", 32'(mem_we), 32'h4);
    checkOutput("sb_addr", 32'(mem_addr), 32'd1);
    checkOutput("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    dataReq(1'b0, 3'b000, 32'h8000_0006, '0, 32'hFFFF_FFAB, 1'b0);
    dataReq(1'b0, 3'b100, 32'h8000_0006, '0, 32'h0000_00AB, 1'b0);

    dataReq(1'b0, 3'b010, 32'h8000_201C, '0, 32'hCAFE_F00D, 1'b0);
    checkOutput("lw_last_en", 32'(mem_en), 32'd1);
    dataReq(1'b0, 3'b010, 32'h8000_2020, '0, 32'h0, 1'b1);
    checkOutput("lw_oor_hi_en", 32'(mem_en), 32'd0);

    dataReq(1'b0, 3'b010, 32'h8000_0002, '0, 32'h0, 1'b1);
    checkOutput("lw_mis_en", 32'(mem_en), 32'd0);
    dataReq(1'b0, 3'b001, 32'h8000_0001, '0, 32'h0, 1'b1);
    checkOutput("lh_mis_en", 32'(mem_en), 32'd0);
    dataReq(1'b0, 3'b010, 32'h7FFF_FFFC, '0, 32'h0, 1'b1);
    checkOutput("lw_oor_lo_en", 32'(mem_en), 32'd0);
    dataReq(1'b1, 3'b100, 32'h8000_0000, 32'h5555_5555, 32'h0, 1'b1);
    checkOutput("st_badf3_we", 32'(mem_we), 32'd0);
    dataReq(1'b0, 3'b011, 32'h8000_0000, '0, 32'h0, 1'b1);
    fetchReq(32'h8000_0002, 32'h0, 1'b1);
    checkOutput("fetch_mis_en", 32'(mem_en), 32'd0);

    // Both requesters saturate the port: expect D,D,D,I repeating
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 3'b100, 32'h8000_0006, '0,
                    32'h0000_0513, 1'b0, 32'h0000_00AB, 1'b0, 1'b1);
      checkOutput("arb_fetch_turn", 32'(if_ready), 32'((i % 4) == 3));
    end

    dataReq(1'b1, 3'b010, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0, 1'b0);
    dataReq(1'b1, 3'b001, 32'h8000_0002, 32'hAAAA_1234, 32'h0, 1'b0);
    checkOutput("sh_we", 32'(mem_we), 32'hC);
    checkOutput("sh_wdata", mem_wdata, 32'h1234_1234);
    dataReq(1'b0, 3'b010, 32'h8000_0000, '0, 32'h1234_BEEF, 1'b0);
    dataReq(1'b0, 3'b101, 32'h8000_0002, '0, 32'h0000_1234, 1'b0);
    dataReq(1'b0, 3'b001, 32'h8000_0000, '0, 32'hFFFF_BEEF, 1'b0);

    // Load granted, then reset the next cycle: its response must vanish
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 3'b010, 32'h8000_0000, '0,
                  '0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 3'b010, 32'h8000_0000,
                  32'h0BAD_0BAD, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("midrst_d_rsp", 32'(d_rsp_valid), 32'd0);
    checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
    idleCycle();
    checkOutput("post_rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("post_rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("post_rst_if_rsp", 32'(if_rsp_valid), 32'd0);
    checkOutput("post_rst_d_rsp", 32'(d_rsp_valid), 32'd0);
    checkOutput("post_rst_d_rdata", d_rdata, 32'd0);
    checkOutput("post_rst_if_rdata", if_rdata, 32'd0);
    checkOutput("post_rst_errs", 32'({if_err, d_err}), 32'd0);
    fetchReq(32'h8000_0000, 32'h1234_BEEF, 1'b0);

    idleCycle();
    idleCycle();
    @(posedge clk);
    #3;
    checkOutput("if_q_drained", 32'(if_q.size()), 32'd0);
    checkOutput("d_q_drained", 32'(d_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the CPU's single-port unified instruction/data memory between two requesters: the instruction-fetch port and the load/store port. Each request uses a valid/ready handshake. The block does four things per access:
- translates the byte address to a word index;
- generates byte-lane write enables for SB/SH/SW;
- aligns and sign/zero-extends load data for LB/LH/LW/LBU/LHU;
- flags misaligned or out-of-range accesses.

It sits between the core's fetch/execute logic and the memory array, and lets the core move from single-cycle combinational memory to a registered-read RAM.

## Interface
Parameters:
- ENTRY, 32'h8000_0000, byte address of word 0
- DEPTH, 2056, memory size in words
- AW, 12, word-index width; must satisfy 2^AW >= DEPTH
- MAX_WAIT, 3, consecutive fetch losses before fetch is forced to win

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- if_valid  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_ready  out  1  fetch granted this cycle
- if_rsp_valid  out  1  fetch response pulse
- if_rdata  out  32  instruction word
- if_err  out  1  fetch misaligned (addr[1:0]!=0) or out of range
- d_valid  in  1  data request
- d_we  in  1  1=store, 0=load
- d_funct3  in  3  RISC-V load/store funct3
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, LSB-aligned
- d_ready  out  1  data granted this cycle
- d_rsp_valid  out  1  data response pulse (loads and stores)
- d_rdata  out  32  extended load result; 0 for stores
- d_err  out  1  misaligned, out of range, or illegal funct3
- mem_en  out  1  RAM access this cycle
- mem_we  out  4  RAM byte write enables
- mem_addr  out  AW  RAM word index
- mem_wdata  out  32  lane-shifted write data
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en

## Operation
Address and range:
- word index = (addr - ENTRY) >> 2
- in range iff ENTRY <= addr and index < DEPTH
- out-of-range and misaligned requests are granted but do not assert mem_en; they respond with err=1 and rdata=0

Alignment:
- byte accesses (funct3 000/100): any offset
- halfword accesses (001/101): addr[0]=0
- word accesses (010): addr[1:0]=00
- any other funct3 gives d_err
- stores accept funct3 000/001/010 only

Store lanes, with off = addr[1:0]:
- SB: mem_we = 1<<off, wdata byte replicated to all 4 lanes
- SH: mem_we = 4'b0011<<off, wdata halfword replicated to both halves
- SW: mem_we = 4'b1111
- stores never read; response rdata = 0

Load extraction:
- select the byte/halfword at off
- LB/LH sign-extend; LBU/LHU zero-extend

Arbitration (combinational grant, both valid):
- data wins
- a wait counter increments on each cycle fetch is valid but loses
- when the counter reaches MAX_WAIT, fetch wins and the counter clears
- the counter clears whenever fetch is granted or if_valid=0
- when a single requester is valid, it is granted

Response register captures requester id, funct3, off and err:
- exactly one rsp_valid pulse per grant, on the cycle after the grant
- no backpressure: requesters must accept responses

## Timing
- Grant: if_ready/d_ready are combinational from valid, in the same cycle; at most one is high.
- Throughput: back-to-back grants every cycle are allowed.
- Latency: one cycle, grant to rsp_valid. d_rdata/if_rdata are combinational from mem_rdata plus the registered lane info.
- Store-then-load to the same word in consecutive cycles returns the new data; the RAM is write-first or the core does not rely on it. This block adds no forwarding.
- Reset values: all ready/rsp_valid/err = 0, rdata = 0, mem_en = 0, mem_we = 0, wait counter = 0.
- Reset mid-operation: a response in flight is dropped (no rsp_valid in the cycle after reset). While reset is high, grants are suppressed and mem_we = 0.
- Same-cycle grant and response to the same requester is legal (pipelined).

## Structure
- Shared package `riscv_pkg`:
  - funct3 constants (F3_B/H/W/BU/HU)
  - ENTRY
  - opcode localparams already used by the core
- One sub-module, `load_align`: combinational extraction and extension from (funct3, off, word) to result. The core reuses it.
- Arbiter and store-lane logic stay in `mem_arbiter`.

## Test plan
- Fetch only at 0x8000_0000, RAM word0 = 0x00000513: if_ready in the same cycle, if_rsp_valid next cycle, if_rdata = 0x00000513, if_err = 0.
- SB of 0xAB to 0x8000_0006: mem_we = 4'b0100, mem_addr = 1. A following LB of the same address returns 0xFFFFFFAB; LBU returns 0x000000AB.
- Both requesters valid continuously, MAX_WAIT = 3:
  - grant pattern D, D, D, I repeating
  - each rsp_valid is on the correct port, one cycle after its grant
- LW at 0x8000_0002, then LH at 0x8000_0001, then LW at 0x7FFF_FFFC:
  - each gets d_rsp_valid with d_err = 1 and d_rdata = 0
  - mem_en stays 0 for all three
- SH of 0x1234 to 0x8000_0002 over word 0xDEADBEEF: the word becomes 0x1234BEEF and LHU at offset 2 returns 0x00001234.
- Assert reset the cycle after a load grant: no d_rsp_valid; all outputs are 0 the cycle after reset; a new fetch after reset deasserts completes normally.
